// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding one UART transmitter: grants a byte, then emits it as an 8N1 frame, LSB first, one bit per txclk_en tick.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit (8E1 frame).
`timescale 1ns/1ps
module uart_tx_sched #(
  parameter  int NUM_REQ = 4,
  localparam int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 txclk_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [REQ_W-1:0]     last_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state_q;
  logic [7:0]         shift_q;
  logic [2:0]         bit_cnt_q;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [REQ_W-1:0]   last_id_q;
`ifdef UART_TX_PARITY_EN
  logic               parity_q;
`endif

  logic [7:0]       byte_arr [NUM_REQ];
  logic [REQ_W-1:0] winner;
  logic [REQ_W-1:0] scan;
  logic             found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign byte_arr[i] = data[8*i +: 8];
  end

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    winner = last_id_q;
    scan   = last_id_q;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (scan == REQ_W'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
      if (!found && req[scan]) begin
        winner = scan;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gnt_q     <= '0;
      last_id_q <= REQ_W'(NUM_REQ - 1);
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            shift_q   <= byte_arr[winner];
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^byte_arr[winner];
`endif
            gnt_q     <= NUM_REQ'(1) << winner;
            last_id_q <= winner;
            busy_q    <= 1'b1;
            state_q   <= S_SYNC;
          end
        end
        // The capture edge never counts as a bit boundary; wait for a fresh tick.
        S_SYNC: begin
          if (txclk_en) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (txclk_en) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (txclk_en) begin
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (txclk_en) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (txclk_en) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign last_id = last_id_q;

endmodule
